// File: rtl/iic_target_pkg.sv
// Shared types and bus-level constants for the I2C register-file target.
package iic_target_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK,
    ST_IGNORE
  } iic_state_e;

  localparam logic BIT_ACK     = 1'b0;
  localparam logic BIT_NACK    = 1'b1;
  localparam logic RW_WRITE    = 1'b0;
  localparam logic RW_READ     = 1'b1;
  localparam logic SDA_PULL    = 1'b0;
  localparam logic SDA_RELEASE = 1'b1;

endpackage

// File: rtl/iic_target_regfile_if.sv
// I2C pin bundle between the IOBUFs (master side) and the target (slave side).
// Open-drain convention: *_t = 1 releases the line, *_t = 0 drives *_o onto it.
interface iic_target_regfile_if;
  logic scl_i;
  logic scl_o;
  logic scl_t;
  logic sda_i;
  logic sda_o;
  logic sda_t;

  modport master (output scl_i, sda_i, input scl_o, scl_t, sda_o, sda_t);
  modport slave  (input scl_i, sda_i, output scl_o, scl_t, sda_o, sda_t);
endinterface

// File: rtl/iic_line_filter.sv
// Two-flop synchroniser plus a hold filter: the level only changes after
// FILT_LEN consecutive equal samples; rise/fall are 1-cycle pulses on that level.
module iic_line_filter #(
  parameter int FILT_LEN = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic line,
  output logic level,
  output logic rise,
  output logic fall
);
  logic [1:0]          sync;
  logic [FILT_LEN-1:0] hist;
  logic                level_d;

  // Reset to the idle-high bus level so release of reset never looks like an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync    <= 2'b11;
      hist    <= '1;
      level   <= 1'b1;
      level_d <= 1'b1;
    end else begin
      sync    <= {sync[0], line};
      hist    <= {hist[FILT_LEN-2:0], sync[1]};
      if (&hist)
        level <= 1'b1;
      else if (~|hist)
        level <= 1'b0;
      level_d <= level;
    end
  end

  assign rise = level & ~level_d;
  assign fall = ~level & level_d;
endmodule

// File: rtl/iic_target_regfile.sv
// I2C target exposing a byte register file; oversampled in aclk, never stretches SCL.
// Fabric side port can write any register and reads with 1-cycle latency.
module iic_target_regfile
  import iic_target_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = 7'h3C,
  parameter int         REG_AW   = 4,
  parameter int         FILT_LEN = 3
) (
  input  logic              aclk,
  input  logic              aresetn,
  iic_target_regfile_if.slave iic,
  input  logic              fab_we,
  input  logic [REG_AW-1:0] fab_addr,
  input  logic [7:0]        fab_wdata,
  output logic [7:0]        fab_rdata,
  output logic              iic_wr_stb,
  output logic [REG_AW-1:0] iic_wr_addr,
  output logic              busy,
  output iic_state_e        dbg_state
);
  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  iic_line_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
    .clk(aclk), .rst_n(aresetn), .line(iic.scl_i),
    .level(scl_lvl), .rise(scl_rise), .fall(scl_fall)
  );
  iic_line_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
    .clk(aclk), .rst_n(aresetn), .line(iic.sda_i),
    .level(sda_lvl), .rise(sda_rise), .fall(sda_fall)
  );

  iic_state_e        state, state_n;
  logic [3:0]        bit_cnt, bit_cnt_n;
  logic [7:0]        shreg, shreg_n;
  logic [REG_AW-1:0] ptr, ptr_n;
  logic              sda_t_q, sda_t_n;
  logic              busy_n;
  logic              commit;
  logic [7:0]        regs [2**REG_AW];
  logic [7:0]        byte_in;
  logic [7:0]        load_byte;
  logic              start, stop;

  assign start     = sda_fall & scl_lvl;
  assign stop      = sda_rise & scl_lvl;
  assign byte_in   = {shreg[6:0], sda_lvl};
  assign load_byte = regs[ptr];

  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
    ptr_n     = ptr;
    sda_t_n   = sda_t_q;
    busy_n    = busy;
    commit    = 1'b0;
    if (start) begin
      state_n   = ST_ADDR;
      bit_cnt_n = 4'd0;
      sda_t_n   = SDA_RELEASE;
      busy_n    = 1'b1;
    end else if (stop) begin
      state_n   = ST_IDLE;
      bit_cnt_n = 4'd0;
      sda_t_n   = SDA_RELEASE;
      busy_n    = 1'b0;
    end else begin
      case (state)
        ST_ADDR, ST_PTR, ST_WDATA: begin
          if (scl_rise) begin
            shreg_n   = byte_in;
            bit_cnt_n = bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              bit_cnt_n = 4'd0;
              case (state)
                ST_ADDR: state_n = (byte_in[7:1] == DEV_ADDR) ? ST_ADDR_ACK : ST_IGNORE;
                ST_PTR: begin
                  ptr_n   = byte_in[REG_AW-1:0];
                  state_n = ST_PTR_ACK;
                end
                default: begin
                  commit  = 1'b1;
                  ptr_n   = ptr + 1'b1;
                  state_n = ST_WDATA_ACK;
                end
              endcase
            end
          end
        end
        // First fall after the 8th bit pulls SDA, the next fall ends the ACK slot.
        ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
          if (scl_fall) begin
            if (sda_t_q == SDA_RELEASE) begin
              sda_t_n = SDA_PULL;
            end else begin
              sda_t_n = SDA_RELEASE;
              if (state == ST_ADDR_ACK && shreg[0] == RW_READ) begin
                state_n = ST_RDATA;
                shreg_n = load_byte;
                sda_t_n = load_byte[7];
                ptr_n   = ptr + 1'b1;
              end else if (state == ST_ADDR_ACK) begin
                state_n = ST_PTR;
              end else begin
                state_n = ST_WDATA;
              end
            end
          end
        end
        ST_RDATA: begin
          if (scl_rise) begin
            bit_cnt_n = bit_cnt + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt == 4'd8) begin
              sda_t_n   = SDA_RELEASE;
              bit_cnt_n = 4'd0;
              state_n   = ST_RDATA_ACK;
            end else begin
              shreg_n = {shreg[6:0], 1'b0};
              sda_t_n = shreg[6];
            end
          end
        end
        // bit_cnt == 1 marks that the controller ACKed and the next byte is due.
        ST_RDATA_ACK: begin
          if (scl_rise) begin
            if (sda_lvl == BIT_NACK)
              state_n = ST_IGNORE;
            else
              bit_cnt_n = 4'd1;
          end else if (scl_fall && bit_cnt == 4'd1) begin
            state_n   = ST_RDATA;
            bit_cnt_n = 4'd0;
            shreg_n   = load_byte;
            sda_t_n   = load_byte[7];
            ptr_n     = ptr + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state   <= ST_IDLE;
      bit_cnt <= 4'd0;
      shreg   <= 8'd0;
      ptr     <= '0;
      sda_t_q <= SDA_RELEASE;
      busy    <= 1'b0;
    end else begin
      state   <= state_n;
      bit_cnt <= bit_cnt_n;
      shreg   <= shreg_n;
      ptr     <= ptr_n;
      sda_t_q <= sda_t_n;
      busy    <= busy_n;
    end
  end

  // The I2C commit is ordered after the fabric write so it wins on a collision.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < 2**REG_AW; i++) regs[i] <= 8'd0;
      fab_rdata   <= 8'd0;
      iic_wr_stb  <= 1'b0;
      iic_wr_addr <= '0;
    end else begin
      if (fab_we) regs[fab_addr] <= fab_wdata;
      if (commit) regs[ptr] <= byte_in;
      iic_wr_stb <= commit;
      if (commit) iic_wr_addr <= ptr;
      fab_rdata <= (commit && ptr == fab_addr) ? byte_in :
                   fab_we                      ? fab_wdata : regs[fab_addr];
    end
  end

  assign iic.scl_o = 1'b0;
  assign iic.scl_t = 1'b1;
  assign iic.sda_o = 1'b0;
  assign iic.sda_t = sda_t_q;
  assign dbg_state = state;
endmodule

// File: tb/tb_iic_target_regfile.sv
// Bench: bit-banged I2C controller plus an array/queue model of the register file.
module tb_iic_target_regfile;
  import iic_target_pkg::*;

  localparam int         NREG = 16;
  localparam int         Q    = 8;
  localparam logic [6:0] DEV  = 7'h3C;

  logic       aclk = 1'b0;
  logic       aresetn = 1'b0;
  logic       fab_we = 1'b0;
  logic [3:0] fab_addr = 4'd0;
  logic [7:0] fab_wdata = 8'd0;
  logic [7:0] fab_rdata;
  logic       iic_wr_stb;
  logic [3:0] iic_wr_addr;
  logic       busy;
  iic_state_e dbg_state;
  logic       ctl_scl = 1'b1;
  logic       ctl_sda = 1'b1;

  iic_target_regfile_if bus();
  assign bus.scl_i = ctl_scl;
  assign bus.sda_i = ctl_sda & bus.sda_t;

  iic_target_regfile dut (
    .aclk(aclk), .aresetn(aresetn), .iic(bus),
    .fab_we(fab_we), .fab_addr(fab_addr), .fab_wdata(fab_wdata), .fab_rdata(fab_rdata),
    .iic_wr_stb(iic_wr_stb), .iic_wr_addr(iic_wr_addr), .busy(busy), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 aclk = ~aclk;
  initial begin
    #3ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // scoreboard
  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] m_regs [NREG];
  int         m_ptr = 0;
  logic [7:0] exp_q[$];
  logic [3:0] exp_stb_q[$];
  logic [3:0] got_stb_q[$];
  logic [7:0] wr_q[$];
  int         sda_low_cnt = 0;

  always @(negedge aclk) begin
    if (aresetn && iic_wr_stb) got_stb_q.push_back(iic_wr_addr);
    if (bus.sda_t === 1'b0) sda_low_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_stb();
    check_eq("stb_count", got_stb_q.size(), exp_stb_q.size());
    while (got_stb_q.size() > 0 && exp_stb_q.size() > 0)
      check_eq("stb_addr", got_stb_q.pop_front(), exp_stb_q.pop_front());
    got_stb_q.delete();
    exp_stb_q.delete();
  endtask

  // driver tasks
  task automatic q_wait(input int n);
    repeat (n) @(negedge aclk);
  endtask

  task automatic bus_start();
    if (ctl_scl == 1'b0) begin
      ctl_sda = 1'b1; q_wait(Q);
      ctl_scl = 1'b1; q_wait(Q);
    end
    ctl_sda = 1'b0; q_wait(Q);
    ctl_scl = 1'b0; q_wait(Q);
  endtask

  task automatic bus_stop();
    ctl_sda = 1'b0; q_wait(Q);
    ctl_scl = 1'b1; q_wait(Q);
    ctl_sda = 1'b1; q_wait(Q);
  endtask

  task automatic send_bit(input logic b, input bit glitch);
    ctl_sda = b; q_wait(Q);
    ctl_scl = 1'b1; q_wait(3);
    if (glitch) begin
      ctl_sda = ~b; q_wait(1); ctl_sda = b;
    end else begin
      q_wait(1);
    end
    q_wait(2*Q - 4);
    ctl_scl = 1'b0; q_wait(Q);
  endtask

  task automatic recv_bit(output logic b);
    ctl_sda = 1'b1; q_wait(Q);
    ctl_scl = 1'b1; q_wait(Q);
    b = bus.sda_i; q_wait(Q);
    ctl_scl = 1'b0; q_wait(Q);
  endtask

  task automatic write_byte(input logic [7:0] d, input bit glitch, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(d[i], glitch);
    recv_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic ack_bit);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      d[i] = b;
    end
    send_bit(ack_bit, 1'b0);
  endtask

  task automatic fab_write(input logic [3:0] a, input logic [7:0] d);
    fab_we = 1'b1; fab_addr = a; fab_wdata = d;
    @(negedge aclk);
    fab_we = 1'b0;
    m_regs[a] = d;
  endtask

  task automatic fab_read(input logic [3:0] a, output logic [7:0] d);
    fab_addr = a;
    @(negedge aclk);
    d = fab_rdata;
  endtask

  task automatic check_all_regs(input string tag);
    logic [7:0] d;
    for (int i = 0; i < NREG; i++) begin
      fab_read(i[3:0], d);
      check_eq(tag, d, m_regs[i]);
    end
  endtask

  // Writes the bytes queued in wr_q starting at ptr_byte.
  task automatic i2c_write(input logic [7:0] ptr_byte, input bit glitch);
    logic ack;
    bus_start();
    write_byte({DEV, RW_WRITE}, 1'b0, ack);
    check_eq("wr_addr_ack", ack, BIT_ACK);
    check_eq("busy_in_xfer", busy, 1'b1);
    write_byte(ptr_byte, 1'b0, ack);
    check_eq("wr_ptr_ack", ack, BIT_ACK);
    m_ptr = ptr_byte % NREG;
    while (wr_q.size() > 0) begin
      write_byte(wr_q[0], glitch, ack);
      check_eq("wr_data_ack", ack, BIT_ACK);
      m_regs[m_ptr] = wr_q.pop_front();
      exp_stb_q.push_back(m_ptr[3:0]);
      m_ptr = (m_ptr + 1) % NREG;
    end
    bus_stop();
    check_eq("busy_after_stop", busy, 1'b0);
    check_stb();
  endtask

  task automatic i2c_read(input int n, input bit set_ptr, input logic [7:0] ptr_byte);
    logic ack;
    logic [7:0] d;
    bus_start();
    if (set_ptr) begin
      write_byte({DEV, RW_WRITE}, 1'b0, ack);
      check_eq("rd_waddr_ack", ack, BIT_ACK);
      write_byte(ptr_byte, 1'b0, ack);
      check_eq("rd_ptr_ack", ack, BIT_ACK);
      m_ptr = ptr_byte % NREG;
      bus_start();
    end
    write_byte({DEV, RW_READ}, 1'b0, ack);
    check_eq("rd_addr_ack", ack, BIT_ACK);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(m_regs[m_ptr]);
      m_ptr = (m_ptr + 1) % NREG;
    end
    for (int i = 0; i < n; i++) begin
      read_byte(d, (i == n - 1) ? BIT_NACK : BIT_ACK);
      check_eq("rd_data", d, exp_q.pop_front());
    end
    bus_stop();
    check_stb();
  endtask

  // Single-byte write to reg 6 with the fabric writing fa in the same window.
  task automatic collide(input logic [3:0] fa, input logic [7:0] fd);
    logic ack;
    logic [7:0] d;
    int t;
    bus_start();
    write_byte({DEV, RW_WRITE}, 1'b0, ack);
    write_byte(8'h06, 1'b0, ack);
    fork
      write_byte(8'h96, 1'b0, ack);
      begin
        fab_we = 1'b1; fab_addr = fa; fab_wdata = fd; t = 0;
        while (!iic_wr_stb && t < 400) begin
          @(negedge aclk);
          t++;
        end
        fab_we = 1'b0;
        check_eq("coll_stb_seen", (t < 400), 1'b1);
      end
    join
    check_eq("coll_ack", ack, BIT_ACK);
    bus_stop();
    m_regs[fa] = fd;
    m_regs[6]  = 8'h96;
    m_ptr = 7;
    exp_stb_q.push_back(4'd6);
    check_stb();
    fab_read(4'd6, d); check_eq("coll_reg6", d, m_regs[6]);
    fab_read(fa, d);   check_eq("coll_fab_reg", d, m_regs[fa]);
  endtask

  initial begin
    logic ack, b;
    logic [7:0] d;
    for (int i = 0; i < NREG; i++) m_regs[i] = 8'd0;

    // reset state
    repeat (3) @(negedge aclk);
    check_eq("rst_sda_t", bus.sda_t, 1'b1);
    check_eq("rst_scl_t", bus.scl_t, 1'b1);
    check_eq("rst_scl_o", bus.scl_o, 1'b0);
    check_eq("rst_sda_o", bus.sda_o, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_stb", iic_wr_stb, 1'b0);
    check_eq("rst_rdata", fab_rdata, 8'd0);
    check_eq("rst_state", dbg_state, ST_IDLE);
    aresetn = 1'b1;
    q_wait(Q);
    check_all_regs("rst_regs");

    // basic write: ptr 2, A5 5A
    wr_q = '{8'hA5, 8'h5A};
    i2c_write(8'h02, 1'b0);
    fab_read(4'd2, d); check_eq("wr_reg2", d, 8'hA5);
    fab_read(4'd3, d); check_eq("wr_reg3", d, 8'h5A);

    // fabric preload then read with repeated start; ptr continues afterwards
    fab_write(4'd0, 8'h11);
    fab_write(4'd1, 8'h22);
    i2c_read(2, 1'b1, 8'h00);
    i2c_read(1, 1'b0, 8'h00);

    // wrong address: never ACKed, busy still tracks the bus
    sda_low_cnt = 0;
    bus_start();
    check_eq("nack_busy_start", busy, 1'b1);
    write_byte({7'h3D, RW_WRITE}, 1'b0, ack);
    check_eq("nack_addr", ack, BIT_NACK);
    check_eq("nack_state", dbg_state, ST_IGNORE);
    write_byte(8'h01, 1'b0, ack);
    check_eq("nack_ptr", ack, BIT_NACK);
    check_eq("nack_busy_mid", busy, 1'b1);
    bus_stop();
    check_eq("nack_busy_stop", busy, 1'b0);
    check_eq("nack_sda_never_low", sda_low_cnt, 0);
    check_stb();
    check_all_regs("nack_regs");

    // pointer wrap
    wr_q = '{8'h77, 8'h88};
    i2c_write(8'h0F, 1'b0);
    fab_read(4'd15, d); check_eq("wrap_reg15", d, 8'h77);
    fab_read(4'd0, d);  check_eq("wrap_reg0", d, 8'h88);

    // SDA glitches while SCL high on every data bit
    wr_q = '{8'hB4, 8'h4B};
    i2c_write(8'hF8, 1'b1);
    check_all_regs("glitch_regs");

    // collisions
    collide(4'd6, 8'hFF);
    collide(4'd9, 8'h5C);

    // randomized transactions
    for (int it = 0; it < 8; it++) begin
      case ($urandom_range(0, 2))
        0: begin
          for (int k = 0, n = $urandom_range(1, 3); k < n; k++)
            wr_q.push_back(8'($urandom_range(0, 255)));
          i2c_write(8'($urandom_range(0, 255)), 1'b0);
        end
        1: i2c_read($urandom_range(1, 3), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
        default: fab_write(4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
      endcase
    end
    check_all_regs("rand_regs");

    // reset during the 5th bit of a read of 0xE7 (that bit is 0, so SDA is pulled)
    fab_write(4'd4, 8'hE7);
    bus_start();
    write_byte({DEV, RW_WRITE}, 1'b0, ack);
    write_byte(8'h04, 1'b0, ack);
    bus_start();
    write_byte({DEV, RW_READ}, 1'b0, ack);
    check_eq("mrst_addr_ack", ack, BIT_ACK);
    for (int i = 0; i < 4; i++) recv_bit(b);
    ctl_sda = 1'b1; q_wait(Q);
    ctl_scl = 1'b1; q_wait(Q);
    check_eq("mrst_pre_sda_t", bus.sda_t, 1'b0);
    aresetn = 1'b0;
    #1;
    check_eq("mrst_sda_t_async", bus.sda_t, 1'b1);
    check_eq("mrst_busy", busy, 1'b0);
    q_wait(2);
    ctl_scl = 1'b1; ctl_sda = 1'b1;
    q_wait(Q);
    aresetn = 1'b1;
    q_wait(Q);
    for (int i = 0; i < NREG; i++) m_regs[i] = 8'd0;
    m_ptr = 0;
    got_stb_q.delete();
    check_eq("mrst_state", dbg_state, ST_IDLE);
    check_all_regs("mrst_regs");
    wr_q = '{8'h3C, 8'hC3};
    i2c_write(8'h05, 1'b0);
    i2c_read(2, 1'b1, 8'h05);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
